aes_cipher_iter: RTL and testbench
==================================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (legal 4, 6, 8).
REQ-002 SHALL have parameter Nr, default Nk+6, round count.
REQ-003 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  pt is offered.
REQ-006 SHALL have port in_ready  output  1  block accepts pt this cycle.
REQ-007 SHALL have port pt  input  128  plaintext block, FIPS-197 byte order.
REQ-008 SHALL have port rkey  input  32 x 4*(Nr+1)  expanded key schedule, word 0 first.
REQ-009 SHALL have port out_valid  output  1  ct holds a finished block.
REQ-010 SHALL have port out_ready  input  1  consumer takes ct this cycle.
REQ-011 SHALL have port ct  output  128  ciphertext block.

Function
REQ-012 SHALL run a 3-state FSM: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; otherwise 0.
REQ-014 Accept (in_valid & in_ready) SHALL load state <= AddRoundKey(pt, rkey[0:3]), set round counter to 1, go to BUSY.
REQ-015 In BUSY, rounds 1..Nr-1 SHALL apply SubBytes, ShiftRows, MixColumns, AddRoundKey(rkey[4r+:4]), one round per cycle.
REQ-016 Round Nr SHALL omit MixColumns; after it the FSM SHALL go to DONE.
REQ-017 Latency: accept at edge T -> out_valid=1 after edge T+Nr (Nr+1 cycles in total; 11/13/15 for Nk=4/6/8).
REQ-018 out_valid SHALL be 1 exactly in DONE; ct and out_valid SHALL hold stable until out_ready=1.
REQ-019 In DONE with out_ready=1 and in_valid=1, the block SHALL accept the new pt in the same cycle and go directly to BUSY (zero-bubble back-to-back).
REQ-020 In DONE with out_ready=1 and in_valid=0, the block SHALL go to IDLE.
REQ-021 in_valid while in_ready=0 SHALL be ignored; the block SHALL not capture pt.
REQ-022 rkey is not captured; the source SHALL keep it stable from accept until the out_valid handshake; the block SHALL not check this.
REQ-023 The round counter SHALL be $clog2(Nr+1) bits wide and SHALL never exceed Nr.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, counter 0, state register 0, out_valid=0, in_ready=1 (once released).
REQ-025 Reset during BUSY or DONE SHALL abandon the block; no out_valid SHALL appear for it.
REQ-026 Deassertion SHALL be synchronised externally; the block's first accept SHALL be possible on the first edge after release.

Configuration
REQ-027 Macro AES_CIPHER_CT_CLEAR_EN defined: ct SHALL read 128'h0 whenever out_valid=0, so intermediate round state never appears on the port.
REQ-028 Macro undefined: ct SHALL be the internal state register directly, including intermediate rounds; only the value under out_valid=1 is meaningful.

Structure
REQ-029 aes_pkg SHALL hold SubBytes, ShiftRows, MixColumns, AddRoundKey, the S-box, and the 4x4x8 state typedef; none are redefined locally.
REQ-030 FSM state enum SHALL be local to the module.
REQ-031 One combinational sub-module aes_enc_round (inputs state, round key, final flag) is natural; the state register, counter and FSM stay in aes_cipher_iter.

Verification
REQ-032 Nk=4, key 000102..0f schedule, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 cycles after accept.
REQ-033 Nk=6, key 000102..17 -> ct dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles; Nk=8, key 000102..1f -> ct 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
REQ-034 Hold out_ready=0 for 20 cycles after out_valid -> ct constant, in_ready=0, new in_valid ignored; then out_ready=1 -> one handshake.
REQ-035 Two blocks back-to-back with out_ready=1 and in_valid=1 held -> second accepted in the first's DONE cycle, outputs spaced exactly Nr+1 cycles apart.
REQ-036 rst_n pulsed low at round 5 -> out_valid stays 0, state IDLE; a fresh C.1 vector then yields the correct ct; with AES_CIPHER_CT_CLEAR_EN, ct=0 throughout BUSY.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128/192/256 round primitives shared by the iterative cipher: S-box,
// state typedef and the four FIPS-197 round transforms.
package aes_pkg;

  // Column-major state: s[c][r], byte 0 of the block is s[0][0] in the MSBs.
  typedef logic [0:3][0:3][7:0] state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = sbox(s[c][r]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = s[(c + r) % 4][r];
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c][0];
      a1 = s[c][1];
      a2 = s[c][2];
      a3 = s[c][3];
      o[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; final_round drops MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  state_t shifted;
  state_t mixed;

  always_comb begin
    shifted   = shift_rows(sub_bytes(state_t'(state_in)));
    mixed     = final_round ? shifted : mix_columns(shifted);
    state_out = add_round_key(mixed, state_t'(round_key));
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per cycle, valid/ready on both sides.
// Define AES_CIPHER_CT_CLEAR_EN to force ct to zero whenever out_valid is low.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [31:0]  rkey [4*(Nr+1)],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct
);

  localparam int             CW         = $clog2(Nr + 1);
  localparam logic [CW-1:0]  LAST_ROUND = CW'(Nr);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t          fsm, fsm_nxt;
  logic [CW-1:0] round_cnt;
  state_t        state_q;
  state_t        init_state;
  logic [127:0]  round_key;
  logic [127:0]  round_out;
  logic          accept;
  logic          final_round;

  assign final_round = (round_cnt == LAST_ROUND);
  assign accept      = in_valid & in_ready;

  // Round r uses schedule words 4r..4r+3; the word index is {r, j}.
  assign round_key  = {rkey[{round_cnt, 2'd0}], rkey[{round_cnt, 2'd1}],
                       rkey[{round_cnt, 2'd2}], rkey[{round_cnt, 2'd3}]};
  assign init_state = add_round_key(state_t'(pt),
                                    state_t'({rkey[0], rkey[1], rkey[2], rkey[3]}));

  aes_enc_round u_round (
    .state_in    (state_q),
    .round_key   (round_key),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = BUSY;
      end
      BUSY: begin
        if (final_round) fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_nxt = in_valid ? BUSY : IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Round datapath: load on accept, advance while busy, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      round_cnt <= '0;
    end else if (accept) begin
      state_q   <= init_state;
      round_cnt <= CW'(1);
    end else if (fsm == BUSY) begin
      state_q <= state_t'(round_out);
      if (!final_round) round_cnt <= round_cnt + CW'(1);
    end
  end

`ifdef AES_CIPHER_CT_CLEAR_EN
  assign ct = out_valid ? state_q : '0;
`else
  assign ct = state_q;
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter using FIPS-197 appendix C vectors.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic         in_ready4, out_valid4;
  logic [127:0] pt4 = '0, ct4;
  logic [31:0]  rk4 [44];

  logic         in_valid_x = 1'b0, out_ready_x = 1'b1;
  logic         in_ready6, out_valid6, in_ready8, out_valid8;
  logic [127:0] pt_x = '0, ct6, ct8;
  logic [31:0]  rk6 [52];
  logic [31:0]  rk8 [60];

  logic [31:0]  wbuf [60];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_cipher_iter #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .pt(pt4),
    .rkey(rk4), .out_valid(out_valid4), .out_ready(out_ready4), .ct(ct4));

  aes_cipher_iter #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready6), .pt(pt_x),
    .rkey(rk6), .out_valid(out_valid6), .out_ready(out_ready_x), .ct(ct6));

  aes_cipher_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready8), .pt(pt_x),
    .rkey(rk8), .out_valid(out_valid8), .out_ready(out_ready_x), .ct(ct8));

  // Independent S-box: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = tb_xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = tb_gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  // Key 00 01 02 ... expanded into wbuf[0 .. 4*(nk+7)-1].
  task automatic expand(input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      wbuf[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = wbuf[i-1];
      if (i % nk == 0) begin
        t  = tb_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = tb_subw(t);
      end
      wbuf[i] = wbuf[i-nk] ^ t;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rst_out_valid4 got=%b want=0", out_valid4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rst_in_ready4 got=%b want=1", in_ready4); end
    total++; if (ct4 !== 128'h0) begin bad++; $display("FAIL rst_ct4 got=%h want=0", ct4); end
    total++; if (out_valid6 !== 1'b0) begin bad++; $display("FAIL rst_out_valid6 got=%b want=0", out_valid6); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL rst_out_valid8 got=%b want=0", out_valid8); end
  endtask

  // First accept lands on the first edge after reset release.
  task automatic test_nk4_vector;
    int n;
    pt4 = PT; out_ready4 = 1'b1; in_valid4 = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready4); end
    n = 0;
    while (out_valid4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 != 11) begin bad++; $display("FAIL nk4_latency got=%0d want=11", n + 1); end
    total++; if (ct4 !== CT4) begin bad++; $display("FAIL nk4_ct got=%h want=%h", ct4, CT4); end
    @(posedge clk); #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL nk4_idle_valid got=%b want=0", out_valid4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL nk4_idle_ready got=%b want=1", in_ready4); end
  endtask

  task automatic test_nk6_nk8;
    int n6, n8;
    logic [127:0] c6, c8;
    n6 = -1; n8 = -1; c6 = '0; c8 = '0;
    pt_x = PT; in_valid_x = 1'b1;
    @(posedge clk); #1;
    in_valid_x = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (out_valid6 === 1'b1 && n6 < 0) begin n6 = n; c6 = ct6; end
      if (out_valid8 === 1'b1 && n8 < 0) begin n8 = n; c8 = ct8; end
    end
    total++; if (n6 + 1 != 13) begin bad++; $display("FAIL nk6_latency got=%0d want=13", n6 + 1); end
    total++; if (c6 !== CT6) begin bad++; $display("FAIL nk6_ct got=%h want=%h", c6, CT6); end
    total++; if (n8 + 1 != 15) begin bad++; $display("FAIL nk8_latency got=%0d want=15", n8 + 1); end
    total++; if (c8 !== CT8) begin bad++; $display("FAIL nk8_ct got=%h want=%h", c8, CT8); end
  endtask

  task automatic test_backpressure;
    int n;
    logic seen;
    out_ready4 = 1'b0; pt4 = PT; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 != 11) begin bad++; $display("FAIL bp_latency got=%0d want=11", n + 1); end
    for (int i = 0; i < 20; i++) begin
      pt4 = ~PT; in_valid4 = 1'b1;
      #1;
      total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready4); end
      @(posedge clk); #1;
      total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, out_valid4); end
      total++; if (ct4 !== CT4) begin bad++; $display("FAIL bp_ct[%0d] got=%h want=%h", i, ct4, CT4); end
    end
    in_valid4 = 1'b0; pt4 = PT; out_ready4 = 1'b1;
    #1;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready4); end
    @(posedge clk); #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL bp_single_handshake got=%b want=0", out_valid4); end
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (out_valid4 === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bp_ignored_input got=%b want=0", seen); end
  endtask

  task automatic test_back_to_back;
    int t1, t2, cyc;
    out_ready4 = 1'b1; pt4 = PT; in_valid4 = 1'b1;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (out_valid4 === 1'b1) begin
        if (t1 < 0) begin
          t1 = cyc;
          total++; if (ct4 !== CT4) begin bad++; $display("FAIL b2b_ct1 got=%h want=%h", ct4, CT4); end
          total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready4); end
        end else begin
          t2 = cyc;
          in_valid4 = 1'b0;
          total++; if (ct4 !== CT4) begin bad++; $display("FAIL b2b_ct2 got=%h want=%h", ct4, CT4); end
        end
      end
    end
    in_valid4 = 1'b0;
    total++; if (t1 != 11) begin bad++; $display("FAIL b2b_first got=%0d want=11", t1); end
    total++; if (t2 - t1 != 11) begin bad++; $display("FAIL b2b_spacing got=%0d want=11", t2 - t1); end
    @(posedge clk); #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", out_valid4); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    out_ready4 = 1'b1; pt4 = PT; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_busy_valid[%0d] got=%b want=0", i, out_valid4); end
`ifdef AES_CIPHER_CT_CLEAR_EN
      total++; if (ct4 !== 128'h0) begin bad++; $display("FAIL mid_busy_ct[%0d] got=%h want=0", i, ct4); end
`endif
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", in_ready4); end
    total++; if (ct4 !== 128'h0) begin bad++; $display("FAIL mid_rst_ct got=%h want=0", ct4); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid4 === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_abandoned got=%b want=0", seen); end
    pt4 = PT; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 != 11) begin bad++; $display("FAIL mid_fresh_latency got=%0d want=11", n + 1); end
    total++; if (ct4 !== CT4) begin bad++; $display("FAIL mid_fresh_ct got=%h want=%h", ct4, CT4); end
  endtask

  initial begin
    expand(4); for (int i = 0; i < 44; i++) rk4[i] = wbuf[i];
    expand(6); for (int i = 0; i < 52; i++) rk6[i] = wbuf[i];
    expand(8); for (int i = 0; i < 60; i++) rk8[i] = wbuf[i];
    test_reset();
    test_nk4_vector();
    test_nk6_nk8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
